// File: rtl/fft_frame_sequencer_pkg.sv
// fft_frame_sequencer_pkg: shared constants and state
// encoding for the FFT frame sequencer.
package fft_frame_sequencer_pkg;

  localparam int N_DEF       = 1024;
  localparam int LOG2N_DEF   = 10;
  localparam int TIMEOUT_DEF = 4096;
  localparam int FC_W        = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_COMPUTE = 3'd3,
    S_UNLOAD  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: drives an FFT core through clear,
// load, compute and unload of one frame per start.
module fft_frame_sequencer
  import fft_frame_sequencer_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int Log2N   = LOG2N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             start,
  input  logic             abort,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_valid,
  input  logic             fft_frame_ready,
  output logic             fft_enable,
  output logic             fft_clear,
  output logic [Log2N-1:0] fft_index,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             irq,
  output logic [FC_W-1:0]  frame_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [Log2N-1:0] LAST = Log2N'(N - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [Log2N-1:0] idx_d;
  logic [FC_W-1:0]  fc_d;
  logic             done_d, err_d, irq_d;
  logic             en_d, clr_d, wrr_d, rdv_d, busy_d;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    idx_d   = fft_index;
    fc_d    = frame_count;
    done_d  = done;
    err_d   = err;
    irq_d   = 1'b0;
    en_d    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        if (wr_valid) begin
          en_d = 1'b1;
          if (fft_index == LAST) begin
            state_d = S_COMPUTE;
            idx_d   = '0;
            tcnt_d  = '0;
          end else begin
            idx_d = fft_index + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        // frame_ready takes priority over a same-cycle timeout
        if (fft_frame_ready) begin
          state_d = S_UNLOAD;
          idx_d   = '0;
        end else if (tcnt_q == TLAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          irq_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_UNLOAD: begin
        if (rd_req) begin
          if (fft_index == LAST) begin
            state_d = S_DONE;
            idx_d   = '0;
            fc_d    = frame_count + 1'b1;
            done_d  = 1'b1;
            irq_d   = 1'b1;
          end else begin
            idx_d = fft_index + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // abort wins over everything, but keeps the sticky status
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      tcnt_d  = '0;
      fc_d    = frame_count;
      done_d  = done;
      err_d   = err;
      irq_d   = 1'b0;
      en_d    = 1'b0;
    end

    en_d   = en_d | (state_d == S_COMPUTE);
    clr_d  = (state_d == S_CLEAR);
    wrr_d  = (state_d == S_LOAD);
    rdv_d  = (state_d == S_UNLOAD);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      fft_index   <= '0;
      frame_count <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      irq         <= 1'b0;
      fft_enable  <= 1'b0;
      fft_clear   <= 1'b0;
      wr_ready    <= 1'b0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      fft_index   <= idx_d;
      frame_count <= fc_d;
      done        <= done_d;
      err         <= err_d;
      irq         <= irq_d;
      fft_enable  <= en_d;
      fft_clear   <= clr_d;
      wr_ready    <= wrr_d;
      rd_valid    <= rdv_d;
      busy        <= busy_d;
    end
  end

endmodule
